// File: rtl/sf_packer_if.sv
// Request and serial-output signals of sf_packer.
//   slave  : the packer side (takes the request, drives the serial bit stream)
//   master : the producer/sink side (drives the request and axior)
// Request: sf_valid/sf_ready handshake plus side info (gr, scalefac_compress,
//   window_switching_flag, block_type, mixed_block_flag, scfsi) and the
//   scalefac_l / scalefac_s arrays.
// Stream:  axiod/axiov/axior bit handshake, done pulse, part2_length.
interface sf_packer_if;
  logic         sf_valid;
  logic         sf_ready;
  logic         gr;
  logic [3:0]   scalefac_compress;
  logic         window_switching_flag;
  logic [1:0]   block_type;
  logic         mixed_block_flag;
  logic [3:0]   scfsi;
  logic [83:0]  scalefac_l;
  logic [143:0] scalefac_s;
  logic         axiod;
  logic         axiov;
  logic         axior;
  logic         done;
  logic [7:0]   part2_length;

  modport slave (
    input  sf_valid, gr, scalefac_compress, window_switching_flag, block_type,
           mixed_block_flag, scfsi, scalefac_l, scalefac_s, axior,
    output sf_ready, axiod, axiov, done, part2_length
  );

  modport master (
    output sf_valid, gr, scalefac_compress, window_switching_flag, block_type,
           mixed_block_flag, scfsi, scalefac_l, scalefac_s, axior,
    input  sf_ready, axiod, axiov, done, part2_length
  );
endinterface

// File: rtl/sf_packer.sv
// Serializes one granule/channel of Layer III scalefactors into the part2
// bit stream, MSB first, one bit per axiov/axior transfer.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : sf_packer_if.slave (request handshake + side info + scalefactors,
//          serial bit stream, done pulse, part2_length)
module sf_packer (
  input  logic        clk,
  input  logic        rst,
  sf_packer_if.slave  bus
);

  localparam int unsigned FRAME_W = 126;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned CNT_W   = 7;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [2:0]         slen1_c, slen2_c;
  logic [FRAME_W-1:0] frame_c;
  logic [LEN_W-1:0]   flen_c;

  function automatic logic [3:0] low_mask(input logic [2:0] n);
    return 4'((5'd1 << n) - 5'd1);
  endfunction

  // slen1/slen2 lookup by scalefac_compress
  always_comb begin
    slen1_c = 3'd0;
    slen2_c = 3'd0;
    case (bus.scalefac_compress)
      4'd0:  begin slen1_c = 3'd0; slen2_c = 3'd0; end
      4'd1:  begin slen1_c = 3'd0; slen2_c = 3'd1; end
      4'd2:  begin slen1_c = 3'd0; slen2_c = 3'd2; end
      4'd3:  begin slen1_c = 3'd0; slen2_c = 3'd3; end
      4'd4:  begin slen1_c = 3'd3; slen2_c = 3'd0; end
      4'd5:  begin slen1_c = 3'd1; slen2_c = 3'd1; end
      4'd6:  begin slen1_c = 3'd1; slen2_c = 3'd2; end
      4'd7:  begin slen1_c = 3'd1; slen2_c = 3'd3; end
      4'd8:  begin slen1_c = 3'd2; slen2_c = 3'd1; end
      4'd9:  begin slen1_c = 3'd2; slen2_c = 3'd2; end
      4'd10: begin slen1_c = 3'd2; slen2_c = 3'd3; end
      4'd11: begin slen1_c = 3'd3; slen2_c = 3'd1; end
      4'd12: begin slen1_c = 3'd3; slen2_c = 3'd2; end
      4'd13: begin slen1_c = 3'd3; slen2_c = 3'd3; end
      4'd14: begin slen1_c = 3'd4; slen2_c = 3'd2; end
      default: begin slen1_c = 3'd4; slen2_c = 3'd3; end
    endcase
  end

  // Pack every transmitted field into one frame at accept time, so skipped
  // fields and slen=0 regions never cost a cycle on the wire. The result is
  // left-aligned so the first bit sits at the MSB of the shift register.
  always_comb begin
    logic               short_mode;
    logic               mixed;
    logic               keep;
    logic [2:0]         sl;
    logic [3:0]         v;
    logic [FRAME_W-1:0] acc;
    logic [LEN_W-1:0]   len;
    short_mode = bus.window_switching_flag && (bus.block_type == 2'd2);
    mixed      = short_mode && bus.mixed_block_flag;
    keep       = 1'b0;
    sl         = 3'd0;
    v          = 4'd0;
    acc        = '0;
    len        = '0;
    for (int k = 0; k < 21; k++) begin
      if (short_mode) begin
        keep = mixed && (k < 8);
      end else begin
        keep = !(bus.gr && ((k < 6)  ? bus.scfsi[0] :
                            (k < 11) ? bus.scfsi[1] :
                            (k < 16) ? bus.scfsi[2] : bus.scfsi[3]));
      end
      sl = (k < 11) ? slen1_c : slen2_c;
      v  = bus.scalefac_l[4*k +: 4];
      if (keep) begin
        acc = (acc << sl) | FRAME_W'(v & low_mask(sl));
        len = len + LEN_W'(sl);
      end
    end
    for (int s = 0; s < 12; s++) begin
      for (int w = 0; w < 3; w++) begin
        keep = short_mode && (!mixed || (s >= 3));
        sl   = (s < 6) ? slen1_c : slen2_c;
        v    = bus.scalefac_s[12*s + 4*w +: 4];
        if (keep) begin
          acc = (acc << sl) | FRAME_W'(v & low_mask(sl));
          len = len + LEN_W'(sl);
        end
      end
    end
    frame_c = acc << (LEN_W'(FRAME_W) - len);
    flen_c  = len;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next state; DONE accepts a new request exactly like IDLE
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.sf_valid) begin
          sr_d    = frame_c;
          cnt_d   = CNT_W'(flen_c);
          len_d   = flen_c;
          state_d = (flen_c == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (bus.axior) begin
          sr_d  = sr_q << 1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != SEND);
    valid_d = (state_d == SEND);
    done_d  = (state_d == DONE);
  end

  assign bus.sf_ready     = ready_q;
  assign bus.axiov        = valid_q;
  assign bus.axiod        = sr_q[FRAME_W-1];
  assign bus.done         = done_q;
  assign bus.part2_length = len_q;

endmodule

// File: tb/tb_sf_packer.sv
// Randomized and directed bench for sf_packer against a field-list model.
module tb_sf_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sf_packer_if bus();
  sf_packer dut (.clk(clk), .rst(rst), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  logic got_q[$];
  int   slen1_t[16] = '{0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4};
  int   slen2_t[16] = '{0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void add_field(input logic [3:0] v, input int sl);
    for (int b = sl - 1; b >= 0; b--) exp_q.push_back(v[b]);
  endfunction

  // Expected bit list built from the field ordering rules
  function automatic void build_model();
    int   s1, s2, grp, first;
    logic short_mode;
    exp_q.delete();
    s1 = slen1_t[bus.scalefac_compress];
    s2 = slen2_t[bus.scalefac_compress];
    short_mode = bus.window_switching_flag && (bus.block_type == 2'd2);
    if (!short_mode) begin
      for (int k = 0; k < 21; k++) begin
        grp = (k < 6) ? 0 : (k < 11) ? 1 : (k < 16) ? 2 : 3;
        if (!(bus.gr && bus.scfsi[grp]))
          add_field(bus.scalefac_l[4*k +: 4], (k < 11) ? s1 : s2);
      end
    end else begin
      first = 0;
      if (bus.mixed_block_flag) begin
        for (int k = 0; k < 8; k++) add_field(bus.scalefac_l[4*k +: 4], s1);
        first = 3;
      end
      for (int s = first; s < 12; s++)
        for (int w = 0; w < 3; w++)
          add_field(bus.scalefac_s[12*s + 4*w +: 4], (s < 6) ? s1 : s2);
    end
  endfunction

  task automatic rand_inputs();
    bus.gr                    = 1'($urandom_range(0, 1));
    bus.scalefac_compress     = 4'($urandom_range(0, 15));
    bus.window_switching_flag = 1'($urandom_range(0, 1));
    bus.block_type            = 2'($urandom_range(0, 3));
    bus.mixed_block_flag      = 1'($urandom_range(0, 1));
    bus.scfsi                 = 4'($urandom_range(0, 15));
    bus.scalefac_l            = 84'({$urandom(), $urandom(), $urandom()});
    bus.scalefac_s            = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic set_req(input logic g, input logic [3:0] comp, input logic wsf,
                         input logic [1:0] bt, input logic mbf, input logic [3:0] sc);
    bus.gr                    = g;
    bus.scalefac_compress     = comp;
    bus.window_switching_flag = wsf;
    bus.block_type            = bt;
    bus.mixed_block_flag      = mbf;
    bus.scfsi                 = sc;
  endtask

  // One frame: accept, collect bits, check timing, stalls and contents.
  // want_len < 0 means the model's length is the expectation.
  task automatic run_frame(input string tag, input int want_len, input bit stall, input bit poke);
    int   len, stalls, gaps, unstable, done_c, errs;
    logic hold_bit;
    bit   holding;
    build_model();
    len = (want_len >= 0) ? want_len : exp_q.size();
    @(negedge clk);
    check({tag, "/ready"}, 32'(bus.sf_ready), 32'd1);
    bus.sf_valid = 1'b1;
    bus.axior    = 1'b1;
    @(posedge clk);
    #1;
    bus.sf_valid = 1'b0;
    rand_inputs();
    got_q.delete();
    stalls = 0; gaps = 0; unstable = 0; done_c = -1; holding = 0; hold_bit = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "/len"}, 32'(bus.part2_length), 32'(len));
        check({tag, "/ready_after_accept"}, 32'(bus.sf_ready), (len == 0) ? 32'd1 : 32'd0);
      end
      if (bus.done) begin
        done_c = c;
        break;
      end
      if (holding && (bus.axiov !== 1'b1 || bus.axiod !== hold_bit)) unstable++;
      if (bus.axiov !== 1'b1) gaps++;
      if (poke && c == 3) begin
        bus.sf_valid = 1'b1;
        rand_inputs();
      end
      if (poke && c == 4) bus.sf_valid = 1'b0;
      bus.axior = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.axiov === 1'b1) begin
        if (bus.axior) got_q.push_back(bus.axiod);
        else stalls++;
      end
      holding  = (bus.axiov === 1'b1) && !bus.axior;
      hold_bit = bus.axiod;
    end
    bus.sf_valid = 1'b0;
    bus.axior    = 1'b1;
    check({tag, "/done_seen"}, 32'(done_c > 0), 32'd1);
    check({tag, "/done_cycle"}, 32'(done_c), 32'(len + stalls + 1));
    check({tag, "/axiov_at_done"}, 32'(bus.axiov), 32'd0);
    check({tag, "/ready_at_done"}, 32'(bus.sf_ready), 32'd1);
    check({tag, "/nbits"}, 32'(got_q.size()), 32'(len));
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) errs++;
    check({tag, "/bit_errors"}, 32'(errs), 32'd0);
    check({tag, "/stall_unstable"}, 32'(unstable), 32'd0);
    check({tag, "/bubbles"}, 32'(gaps), 32'd0);
    @(negedge clk);
    check({tag, "/done_pulse_end"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [83:0]  l;
    logic [143:0] s;
    rst          = 1'b0;
    bus.sf_valid = 1'b0;
    bus.axior    = 1'b1;
    set_req(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0);
    bus.scalefac_l = '0;
    bus.scalefac_s = '0;
    repeat (3) @(negedge clk);
    check("rst/ready", 32'(bus.sf_ready), 32'd1);
    check("rst/axiov", 32'(bus.axiov), 32'd0);
    check("rst/axiod", 32'(bus.axiod), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/len", 32'(bus.part2_length), 32'd0);
    rst = 1'b1;

    // Long, gr=0, slen 1/1, value k per sfb
    for (int k = 0; k < 21; k++) l[4*k +: 4] = 4'(k);
    set_req(1'b0, 4'd5, 1'b0, 2'd0, 1'b0, 4'b1111);
    bus.scalefac_l = l;
    run_frame("long_gr0", 21, 1'b0, 1'b0);

    // Long, gr=1 with scfsi groups 0 and 2 reused
    set_req(1'b1, 4'd15, 1'b0, 2'd0, 1'b0, 4'b0101);
    bus.scalefac_l = 84'({$urandom(), $urandom(), $urandom()});
    run_frame("long_scfsi", 35, 1'b0, 1'b0);

    // Short non-mixed, all ones then 4'h5
    for (int i = 0; i < 21; i++) l[4*i +: 4] = 4'hF;
    for (int i = 0; i < 36; i++) s[4*i +: 4] = 4'hF;
    set_req(1'b0, 4'd12, 1'b1, 2'd2, 1'b0, 4'd0);
    bus.scalefac_l = l;
    bus.scalefac_s = s;
    run_frame("short_F", 90, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) s[4*i +: 4] = 4'h5;
    set_req(1'b0, 4'd12, 1'b1, 2'd2, 1'b0, 4'd0);
    bus.scalefac_s = s;
    run_frame("short_5", 90, 1'b0, 1'b0);

    // Mixed with random backpressure, then the same frame unstalled
    l = 84'({$urandom(), $urandom(), $urandom()});
    s = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    set_req(1'b1, 4'd9, 1'b1, 2'd2, 1'b1, 4'b1111);
    bus.scalefac_l = l;
    bus.scalefac_s = s;
    run_frame("mixed_stall", 70, 1'b1, 1'b0);
    set_req(1'b1, 4'd9, 1'b1, 2'd2, 1'b1, 4'b1111);
    bus.scalefac_l = l;
    bus.scalefac_s = s;
    run_frame("mixed_nostall", 70, 1'b0, 1'b0);

    // Zero length
    set_req(1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 4'd0);
    run_frame("zero_len", 0, 1'b0, 1'b0);

    // sf_valid during SEND is ignored
    set_req(1'b0, 4'd15, 1'b0, 2'd0, 1'b0, 4'd0);
    bus.scalefac_l = 84'({$urandom(), $urandom(), $urandom()});
    run_frame("poke_send", 74, 1'b1, 1'b1);

    // Reset after 10 bits of a 90-bit frame
    set_req(1'b0, 4'd12, 1'b1, 2'd2, 1'b0, 4'd0);
    @(negedge clk);
    bus.sf_valid = 1'b1;
    bus.axior    = 1'b1;
    @(posedge clk);
    #1;
    bus.sf_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst/axiov", 32'(bus.axiov), 32'd0);
    check("midrst/ready", 32'(bus.sf_ready), 32'd1);
    check("midrst/done", 32'(bus.done), 32'd0);
    check("midrst/len", 32'(bus.part2_length), 32'd0);
    check("midrst/axiod", 32'(bus.axiod), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_req(1'b0, 4'd12, 1'b1, 2'd2, 1'b0, 4'd0);
    bus.scalefac_s = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    run_frame("after_rst", 90, 1'b0, 1'b0);

    // Random frames
    for (int n = 0; n < 40; n++) begin
      rand_inputs();
      run_frame($sformatf("rand%0d", n), -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sf_packer.md
# sf_packer

Serializes one granule/channel of MP3 Layer III scalefactors into the part2 bitstream, MSB-first, one bit per handshake. It is the inverse of `sf_parser`: it takes the same side-info fields plus parallel scalefactor arrays and emits exactly the bit sequence `sf_parser` consumes. It is used for encoder-side bitstream generation and for closed-loop parser benches.

## Interface

Parameters: none.

- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `sf_valid` in 1: request; inputs below are sampled when `sf_valid && sf_ready`
- `sf_ready` out 1: high in IDLE; the block accepts a request
- `gr` in 1: granule index (0/1)
- `scalefac_compress` in 4: index into slen1/slen2 table
- `window_switching_flag` in 1: side-info flag
- `block_type` in 2: side-info block type
- `mixed_block_flag` in 1: side-info flag
- `scfsi` in 4: scfsi[0]=sfb 0–5, [1]=6–10, [2]=11–15, [3]=16–20
- `scalefac_l` in 84: 21 long sfb × 4 bits; sfb k at [4k+3:4k]
- `scalefac_s` in 144: 12 sfb × 3 windows × 4 bits; (sfb s, window w) at [12s+4w+3 : 12s+4w]
- `axiod` out 1: serial data bit
- `axiov` out 1: serial bit valid
- `axior` in 1: sink ready; a bit transfers on an edge where `axiov && axior`
- `done` out 1: one-cycle pulse when the frame is complete
- `part2_length` out 8: number of bits in the frame; max 126

## Operation

- Table, index 0..15:
  - slen1 = 0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4
  - slen2 = 0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3
- Short mode: `window_switching_flag && block_type==2`. Every other combination is long mode.
- Long-mode order: sfb 0..20.
  - sfb 0–10 use slen1; sfb 11–20 use slen2.
  - If `gr==1` and the scfsi bit for a group is 1, that whole group is omitted.
- Short, non-mixed order: sfb 0..11, windows 0,1,2 within each sfb.
  - sfb 0–5 use slen1; sfb 6–11 use slen2.
- Short, mixed order:
  - long sfb 0–7 with slen1,
  - then short sfb 3–5 (windows 0..2) with slen1,
  - then short sfb 6–11 with slen2.
- scfsi is ignored in short mode and when `gr==0`.
- Field encoding:
  - Each field sends the low slen bits of its value, MSB first. Upper bits are discarded.
  - A field with slen=0 emits nothing.
- FSM states:
  - IDLE → SEND on accept with part2_length>0.
  - IDLE → DONE on accept with part2_length=0.
  - SEND → DONE on transfer of the last bit.
  - DONE → IDLE unconditionally.
- `sf_valid` outside IDLE is ignored. Inputs are latched on accept; later input changes have no effect on the frame.
- Output is contiguous. While `axior` stays high, `axiov` never drops between fields; skipped fields and slen=0 regions cause no bubbles.

## Timing

- Reset values: `sf_ready`=1, `axiov`=0, `axiod`=0, `done`=0, `part2_length`=0. FSM in IDLE, counters cleared.
- Accept at edge N: from N+1, `sf_ready`=0 and `part2_length` holds the computed length until the next accept.
  - If length>0, `axiov`=1 with the first bit from N+1.
- Backpressure: while `axiov && !axior`, `axiod` and `axiov` hold stable.
- Last bit transfers at edge M: from M+1, `axiov`=0, `done`=1, `sf_ready`=1 (DONE). At M+2, `done`=0 (IDLE).
  - An accept at M+1 is legal; DONE accepts like IDLE.
- Zero length: `done`=1 and `sf_ready`=1 from N+1. `axiov` is never raised.
- `rst` low mid-frame: outputs go immediately to reset values and the frame is dropped. After release, the next accept starts from field 0.
- Latency: first bit visible one cycle after accept. A frame of L bits with `axior` tied high completes with `done` at N+L+1.

## Test plan

- Long, gr=0, compress=5 (slen 1/1), `scalefac_l[k]`=k, `axior`=1 → part2_length=21, bits = k&1 for k=0..20, `done` at N+22.
- Long, gr=1, scfsi=4'b0101, compress=15 (4/3) → sfb 0–5 and 11–15 omitted.
  - Emits sfb 6–10 as 4 bits, then sfb 16–20 as 3 bits; part2_length=35.
- Short non-mixed, compress=12 (3/2), all scalefacs = 4'hF → part2_length=90: 54 ones, then 36 ones.
  - Repeat with values 4'h5: each slen1 field = 101, each slen2 field = 01.
- Mixed, compress=9 (2/2) → part2_length=70. Order: long 0–7, short 3–5 ×3 windows, short 6–11 ×3 windows.
  - Pseudo-random `axior` must leave `axiod` stable during stalls and give an identical sequence.
- compress=0 → part2_length=0, `axiov` never high, `done` at N+1. `sf_valid` during SEND of another frame is ignored.
- Reset and loopback:
  - Assert `rst` low after 10 bits of a 90-bit frame → `axiov`=0 immediately. A new frame after release starts at field 0.
  - Loopback into `sf_parser` with matching side info reproduces the input scalefactors.
